// File: rtl/health_bar_pkg.sv
// Shared types and palette for the animated health bar.
// Colours are RGB444; the animator FSM encoding is shared between the animator and the bench.
package health_bar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HEAL  = 2'd3
  } hb_state_t;

  localparam logic [11:0] C_OFF    = 12'h000;
  localparam logic [11:0] C_BORDER = 12'h888;
  localparam logic [11:0] C_FLASH  = 12'hFFF;
  localparam logic [11:0] C_HI     = 12'h0F0;
  localparam logic [11:0] C_MID    = 12'hFF0;
  localparam logic [11:0] C_LO     = 12'hF00;
  localparam logic [11:0] C_GHOST  = 12'hF80;
  localparam logic [11:0] C_BG     = 12'h222;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/health_bar_anim.sv
// Health animator: captures the requested health every cycle and, once per frame,
// moves fill/ghost toward it through the IDLE/WAIT/DRAIN/HEAL states.
module health_bar_anim
  import health_bar_pkg::*;
#(
  parameter int WIDTH        = 96,
  parameter int HP_W         = 7,
  parameter int STEP         = 1,
  parameter int GHOST_DELAY  = 30,
  parameter int FLASH_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_frame,
  input  logic [HP_W-1:0] health,
  output logic [HP_W-1:0] fill,
  output logic [HP_W-1:0] ghost,
  output logic            flash_on,
  output logic            busy
);

  localparam int HOLD_W  = max_int(1, $clog2(GHOST_DELAY + 1));
  localparam int FLASH_W = max_int(2, $clog2(FLASH_FRAMES + 1));

  localparam logic [HP_W-1:0]    FULL       = HP_W'(WIDTH);
  localparam logic [HP_W-1:0]    STEP_V     = HP_W'(STEP);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(GHOST_DELAY);
  localparam logic [FLASH_W-1:0] FLASH_INIT = FLASH_W'(FLASH_FRAMES);

  hb_state_t          state, state_n;
  logic [HP_W-1:0]    target;
  logic [HP_W-1:0]    fill_q, fill_n;
  logic [HP_W-1:0]    ghost_q, ghost_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;
  logic [FLASH_W-1:0] flash_q, flash_n;

  function automatic logic [HP_W-1:0] max_hp(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Callers guarantee g >= floor, so the difference never wraps.
  function automatic logic [HP_W-1:0] step_down(input logic [HP_W-1:0] g, input logic [HP_W-1:0] floor);
    return ((g - floor) > STEP_V) ? (g - STEP_V) : floor;
  endfunction

  function automatic logic [HP_W-1:0] step_up(input logic [HP_W-1:0] f, input logic [HP_W-1:0] t);
    return ((t - f) > STEP_V) ? (f + STEP_V) : t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      target  <= FULL;
      fill_q  <= FULL;
      ghost_q <= FULL;
      hold_q  <= '0;
      flash_q <= '0;
    end else begin
      state   <= state_n;
      target  <= (health > FULL) ? FULL : health;
      fill_q  <= fill_n;
      ghost_q <= ghost_n;
      hold_q  <= hold_n;
      flash_q <= flash_n;
    end
  end

  always_comb begin
    state_n = state;
    fill_n  = fill_q;
    ghost_n = ghost_q;
    hold_n  = hold_q;
    flash_n = flash_q;
    if (new_frame) begin
      if (flash_q != '0) flash_n = flash_q - FLASH_W'(1);
      case (state)
        // A heal that ends with the ghost still above fill finishes by draining,
        // so IDLE is only ever entered with ghost == fill.
        IDLE, HEAL: begin
          if (target < fill_q) begin
            fill_n  = target;
            hold_n  = HOLD_INIT;
            flash_n = FLASH_INIT;
            state_n = WAIT;
          end else if (target > fill_q) begin
            fill_n  = step_up(fill_q, target);
            ghost_n = max_hp(ghost_q, fill_n);
            if (fill_n == target) state_n = (ghost_n == fill_n) ? IDLE : DRAIN;
            else                  state_n = HEAL;
          end else begin
            state_n = (ghost_q == fill_q) ? IDLE : DRAIN;
          end
        end
        WAIT: begin
          if (target < fill_q) begin
            fill_n  = target;
            hold_n  = HOLD_INIT;
            flash_n = FLASH_INIT;
          end else if (target > fill_q) begin
            ghost_n = max_hp(ghost_q, target);
            state_n = HEAL;
          end else if (hold_q == '0) begin
            state_n = DRAIN;
          end else begin
            hold_n = hold_q - HOLD_W'(1);
          end
        end
        // A hit while draining lowers the floor but never pauses the drain.
        DRAIN: begin
          if (target > fill_q) begin
            ghost_n = max_hp(ghost_q, target);
            state_n = HEAL;
          end else begin
            if (target < fill_q) begin
              fill_n  = target;
              flash_n = FLASH_INIT;
            end
            ghost_n = step_down(ghost_q, fill_n);
            if (ghost_n == fill_n) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign fill     = fill_q;
  assign ghost    = ghost_q;
  assign flash_on = (flash_q != '0) && flash_q[1];
  assign busy     = (state != IDLE);

endmodule

// File: rtl/health_bar_animated.sv
// Animated bordered health bar: animator plus a one-cycle registered pixel renderer
// producing RGB444 for the compositor.
module health_bar_animated
  import health_bar_pkg::*;
#(
  parameter int POS_X        = 480,
  parameter int POS_Y        = 720,
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 32,
  parameter int HP_W         = 7,
  parameter int STEP         = 1,
  parameter int GHOST_DELAY  = 30,
  parameter int FLASH_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            new_frame_in,
  input  logic [HP_W-1:0] health_in,
  output logic [11:0]     pixel_out,
  output logic            empty_out,
  output logic            busy_out
);

  localparam logic [11:0] X0      = 12'(POS_X);
  localparam logic [11:0] X1      = 12'(POS_X + WIDTH + 1);
  localparam logic [11:0] Y0      = 12'(POS_Y);
  localparam logic [11:0] Y1      = 12'(POS_Y + HEIGHT - 1);
  localparam logic [11:0] HALF    = 12'(WIDTH / 2);
  localparam logic [11:0] QUARTER = 12'(WIDTH / 4);

  logic [HP_W-1:0] fill;
  logic [HP_W-1:0] ghost;
  logic            flash_on;
  logic            anim_busy;

  logic [11:0] x, y, col, fill12, ghost12;
  logic        in_box, on_border;
  logic [11:0] level, colour;

  health_bar_anim #(
    .WIDTH        (WIDTH),
    .HP_W         (HP_W),
    .STEP         (STEP),
    .GHOST_DELAY  (GHOST_DELAY),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_anim (
    .clk       (clk),
    .rst       (rst),
    .new_frame (new_frame_in),
    .health    (health_in),
    .fill      (fill),
    .ghost     (ghost),
    .flash_on  (flash_on),
    .busy      (anim_busy)
  );

  // col is only meaningful inside the box; outside it may wrap, but is never used there.
  always_comb begin
    x         = {1'b0, hcount_in};
    y         = {2'b00, vcount_in};
    col       = x - X0 - 12'd1;
    fill12    = 12'(fill);
    ghost12   = 12'(ghost);
    in_box    = (x >= X0) && (x <= X1) && (y >= Y0) && (y <= Y1);
    on_border = (x == X0) || (x == X1) || (y == Y0) || (y == Y1);
    level     = (fill12 > HALF) ? C_HI : ((fill12 > QUARTER) ? C_MID : C_LO);
    colour    = C_OFF;
    if (in_box) begin
      if (on_border)          colour = flash_on ? C_FLASH : C_BORDER;
      else if (col < fill12)  colour = level;
      else if (col < ghost12) colour = C_GHOST;
      else                    colour = C_BG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out <= '0;
      empty_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      pixel_out <= valid_in ? colour : C_OFF;
      empty_out <= (fill == '0);
      busy_out  <= anim_busy;
    end
  end

endmodule
